// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared state encoding and default field constants for fifo_reader
package fifo_reader_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} rd_state_t;
  localparam int ID_W_DEF = 8;
  localparam logic [7:0] BCAST_DEF = 8'hFF;
endpackage

// File: rtl/fifo_reader_stats.sv
// fifo_reader_stats: accepted-word counter (wrapping) and stall-cycle counter (saturating)
module fifo_reader_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        ready,
  output logic [31:0] words_o,
  output logic [31:0] stall_o
);
  always_ff @(posedge clk) begin
    if (rst) begin
      words_o <= '0;
      stall_o <= '0;
    end else begin
      if (valid && ready) words_o <= words_o + 32'd1;
      if (valid && !ready && stall_o != 32'hFFFF_FFFF) stall_o <= stall_o + 32'd1;
    end
  end
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pops FIFO words onto a valid/ready handshake and flags broadcast IDs; FIFO_READER_STATS_EN adds counters
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int width = 16,
  parameter int id_w = ID_W_DEF,
  parameter logic [id_w-1:0] broadcast = id_w'(BCAST_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pndng_i,
  input  logic [width-1:0] fifo_dato_i,
  output logic             pop_o,
  output logic [width-1:0] dato_o,
  output logic [id_w-1:0]  id_o,
  output logic             bcast_o,
  output logic             valid_o,
`ifdef FIFO_READER_STATS_EN
  output logic [31:0]      words_o,
  output logic [31:0]      stall_o,
`endif
  input  logic             ready_i
);
  rd_state_t state, nxt;
  logic bcast;
  always_comb begin
    nxt = state == IDLE ? (pndng_i ? SETTLE : IDLE) : (ready_i ? IDLE : HOLD);
    pop_o = !rst && state == IDLE && pndng_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dato_o <= '0;
      bcast <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      state <= nxt;
      valid_o <= nxt != IDLE;
      if (pop_o) begin
        dato_o <= fifo_dato_i;
        bcast <= fifo_dato_i[width-1 -: id_w] == broadcast;
      end
    end
  end
  assign id_o = dato_o[width-1 -: id_w];
  assign bcast_o = valid_o && bcast;
`ifdef FIFO_READER_STATS_EN
  fifo_reader_stats u_stats (
    .clk(clk),
    .rst(rst),
    .valid(valid_o),
    .ready(ready_i),
    .words_o(words_o),
    .stall_o(stall_o)
  );
`endif
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: randomized and directed checks of fifo_reader against a word-level reference model
module tb_fifo_reader;
  logic clk = 1'b0;
  logic rst, pndng_i, pop_o, bcast_o, valid_o, ready_i;
  logic [15:0] fifo_dato_i, dato_o;
  logic [7:0] id_o;
`ifdef FIFO_READER_STATS_EN
  logic [31:0] words_o, stall_o;
`endif
  int checks = 0, errors = 0, npop = 0;
  logic [15:0] q[$];
  bit m_valid = 0;
  logic [15:0] m_data = '0;
  logic [31:0] m_words = '0, m_stall = '0;
  always #5 clk = ~clk;
  fifo_reader dut (
    .clk(clk),
    .rst(rst),
    .pndng_i(pndng_i),
    .fifo_dato_i(fifo_dato_i),
    .pop_o(pop_o),
    .dato_o(dato_o),
    .id_o(id_o),
    .bcast_o(bcast_o),
    .valid_o(valid_o),
`ifdef FIFO_READER_STATS_EN
    .words_o(words_o),
    .stall_o(stall_o),
`endif
    .ready_i(ready_i)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cycle(input bit r, input bit rdy);
    bit dp;
    rst = r;
    ready_i = rdy;
    pndng_i = q.size() != 0;
    fifo_dato_i = pndng_i ? q[0] : 16'h0;
    #1;
    check("pop", pop_o, !r && !m_valid && q.size() != 0);
    dp = pop_o;
    if (dp === 1'b1) npop++;
    @(posedge clk);
    @(negedge clk);
    if (r) begin
      m_valid = 0;
      m_data = '0;
      m_words = '0;
      m_stall = '0;
    end else if (m_valid) begin
      if (rdy) begin
        m_valid = 0;
        m_words++;
      end else if (m_stall != 32'hFFFF_FFFF) m_stall++;
    end else if (q.size() != 0) begin
      m_data = q[0];
      m_valid = 1;
    end
    if (dp === 1'b1 && q.size() != 0) void'(q.pop_front());
    check("valid", valid_o, m_valid);
    check("dato", dato_o, m_data);
    check("id", id_o, m_data[15:8]);
    check("bcast", bcast_o, m_valid && m_data[15:8] == 8'hFF);
`ifdef FIFO_READER_STATS_EN
    check("words", words_o, m_words);
    check("stall", stall_o, m_stall);
`endif
  endtask
  initial begin
    cycle(1, 0);
    cycle(1, 1);
    check("rst_valid", valid_o, 0);
    check("rst_dato", dato_o, 0);
    npop = 0;
    for (int i = 0; i < 20; i++) cycle(0, 1'($urandom));
    check("empty_pops", npop, 0);
    q.push_back(16'h0006);
    cycle(0, 1);
    check("single_dato", dato_o, 16'h0006);
    check("single_id", id_o, 8'h00);
    cycle(0, 1);
    check("single_done", valid_o, 0);
    q.push_back(16'h0006);
    q.push_back(16'h000A);
    npop = 0;
    for (int i = 0; i < 5; i++) cycle(0, 0);
    check("bp_pops", npop, 1);
    check("bp_hold", dato_o, 16'h0006);
    cycle(0, 1);
    cycle(0, 1);
    check("bp_second", dato_o, 16'h000A);
    cycle(0, 1);
    q.push_back(16'hFF3C);
    cycle(0, 0);
    check("bc_id", id_o, 8'hFF);
    check("bc_flag", bcast_o, 1);
    cycle(0, 1);
    q.push_back(16'h013C);
    cycle(0, 1);
    check("nbc_flag", bcast_o, 0);
    cycle(0, 1);
    q.push_back(16'h1234);
    q.push_back(16'h5678);
    cycle(0, 0);
    cycle(0, 0);
    cycle(0, 0);
    npop = 0;
    cycle(1, 0);
    check("rst_mid_valid", valid_o, 0);
    check("rst_mid_dato", dato_o, 0);
    check("rst_mid_pops", npop, 0);
    cycle(0, 1);
    cycle(0, 1);
    cycle(0, 1);
    cycle(0, 1);
    cycle(1, 0);
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(16'($urandom));
    cycle(0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1);
`ifdef FIFO_READER_STATS_EN
    check("stats_words", words_o, 8);
    check("stats_stall", stall_o, 3);
`endif
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(2) == 0)
        q.push_back($urandom_range(3) == 0 ? {8'hFF, 8'($urandom)} : 16'($urandom));
      cycle($urandom_range(99) == 0, 1'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
